// File: rtl/mips_cpu_pkg.sv
// Shared types and default constants for the MIPS core front end.
package mips_cpu_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Default PC after reset (kseg1 boot ROM).
    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;

    // A control transfer to this address stops the core.
    localparam logic [31:0] HALT_ADDR_DEF    = 32'h00000000;

    // Sequential successor of a PC; 32-bit wrap is intentional.
    function automatic logic [31:0] seq_pc(input logic [31:0] cur);
        return cur + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer.
// Holds the architectural PC, fetches the word at PC over a read/waitrequest
// bus, presents it to the decoder, applies the next PC on pc_update with a
// one-instruction branch delay slot, and halts when control reaches HALT_ADDR.
module pc_fetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcnext,
    input  logic        redirect,
    input  logic        pc_update,
    output logic [31:0] pc,
    output logic [31:0] i_address,
    output logic        i_read,
    input  logic        i_waitrequest,
    input  logic [31:0] i_readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        active
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_pending_target;
    logic        r_pending_valid;
    logic [31:0] r_instr;
    logic        r_instr_valid;

    // Per-cycle decisions derived from state and inputs.
    logic        w_retire;          // pc_update accepted (only in EXEC)
    logic        w_capture;         // bus returned the fetched word
    logic [31:0] w_new_pc;
    logic        w_pending_valid_nxt;
    logic [31:0] w_pending_target_nxt;

    // Next-state, retire and delay-slot resolution.
    always_comb begin
        w_next_state         = r_state;
        w_retire             = 1'b0;
        w_capture            = 1'b0;
        w_new_pc             = r_pc;
        w_pending_valid_nxt  = r_pending_valid;
        w_pending_target_nxt = r_pending_target;

        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                if (!i_waitrequest) begin
                    w_capture    = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                if (pc_update) begin
                    w_retire = 1'b1;
                    if (r_pending_valid) begin
                        // Delay slot just retired: take the stored target.
                        // A redirect arriving now is dropped on purpose.
                        w_new_pc            = r_pending_target;
                        w_pending_valid_nxt = 1'b0;
                    end else if (redirect) begin
                        // Taken branch: run the delay slot first.
                        w_new_pc             = seq_pc(r_pc);
                        w_pending_target_nxt = pcnext;
                        w_pending_valid_nxt  = 1'b1;
                    end else begin
                        w_new_pc = pcnext;
                    end
                    w_next_state = (w_new_pc == HALT_ADDR) ? HALTED : FETCH;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC and delay-slot pending target; change only when an instruction retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= RESET_VECTOR;
            r_pending_valid  <= 1'b0;
            r_pending_target <= 32'd0;
        end else if (w_retire) begin
            r_pc             <= w_new_pc;
            r_pending_valid  <= w_pending_valid_nxt;
            r_pending_target <= w_pending_target_nxt;
        end
    end

    // Instruction latch: captured when the bus completes, invalidated on retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
        end else if (w_capture) begin
            r_instr       <= i_readdata;
            r_instr_valid <= 1'b1;
        end else if (w_retire) begin
            r_instr_valid <= 1'b0;
        end
    end

    // Bus and status outputs are decoded straight from registered state,
    // so the read request is stable for as long as waitrequest holds it.
    assign i_read      = (r_state == FETCH);
    assign i_address   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign active      = (r_state != HALTED);

endmodule
